// File: rtl/core_seq_ctrl.sv
// Multi-cycle fetch/execute/memory/write-back sequencer that owns the PC.
// Optional SEQ_PERF_CNT_EN adds 64-bit cycle and retire counters.
module core_seq_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 32'h8000_0000,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [ADDR_WIDTH-1:0] ifu_req_addr,
  input  logic                  ifu_resp_valid,
  input  logic [DATA_WIDTH-1:0] ifu_resp_data,
  output logic [DATA_WIDTH-1:0] inst,
  input  logic [1:0]            dec_mem_op,
  input  logic                  dec_halt,
  output logic                  exu_valid,
  input  logic                  exu_wen,
  input  logic [4:0]            exu_waddr,
  input  logic [DATA_WIDTH-1:0] exu_wdata,
  input  logic [ADDR_WIDTH-1:0] exu_next_pc,
  output logic                  lsu_req_valid,
  input  logic                  lsu_req_ready,
  input  logic                  lsu_resp_valid,
  input  logic [DATA_WIDTH-1:0] lsu_rdata,
  output logic                  rf_wen,
  output logic [4:0]            rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  retire,
  output logic                  halted,
  output logic                  error
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [63:0]           cycle_cnt,
  output logic [63:0]           retire_cnt
`endif
);

  typedef enum logic [3:0] {IDLE, F_REQ, F_WAIT, EXEC, M_REQ, M_WAIT, WB, HALT, ERR} state_t;

  localparam logic [7:0] TMAX = 8'(TIMEOUT - 1);

  state_t                state;
  logic [7:0]            timer;
  logic                  cap_wen;
  logic                  cap_load;
  logic [4:0]            cap_waddr;
  logic [DATA_WIDTH-1:0] cap_wdata;
  logic [ADDR_WIDTH-1:0] cap_npc;

  assign ifu_req_addr = pc;
  assign rf_waddr     = cap_waddr;
  assign rf_wdata     = cap_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      inst          <= '0;
      timer         <= '0;
      ifu_req_valid <= 1'b0;
      lsu_req_valid <= 1'b0;
      exu_valid     <= 1'b0;
      rf_wen        <= 1'b0;
      retire        <= 1'b0;
      halted        <= 1'b0;
      error         <= 1'b0;
      cap_wen       <= 1'b0;
      cap_load      <= 1'b0;
      cap_waddr     <= '0;
      cap_wdata     <= '0;
      cap_npc       <= '0;
    end else begin
      // Single-cycle pulses default low; set only on entry to their state.
      exu_valid <= 1'b0;
      rf_wen    <= 1'b0;
      retire    <= 1'b0;
      case (state)
        IDLE: begin
          ifu_req_valid <= 1'b1;
          timer         <= '0;
          state         <= F_REQ;
        end
        F_REQ: begin
          if (ifu_req_ready) begin
            ifu_req_valid <= 1'b0;
            timer         <= '0;
            state         <= F_WAIT;
          end else if (timer == TMAX) begin
            ifu_req_valid <= 1'b0;
            error         <= 1'b1;
            state         <= ERR;
          end else timer <= timer + 8'd1;
        end
        F_WAIT: begin
          if (ifu_resp_valid) begin
            inst      <= ifu_resp_data;
            exu_valid <= 1'b1;
            state     <= EXEC;
          end else if (timer == TMAX) begin
            error <= 1'b1;
            state <= ERR;
          end else timer <= timer + 8'd1;
        end
        EXEC: begin
          cap_waddr <= exu_waddr;
          cap_wdata <= exu_wdata;
          cap_npc   <= exu_next_pc;
          cap_load  <= (dec_mem_op == 2'b01);
          if (dec_halt) begin
            halted <= 1'b1;
            state  <= HALT;
          end else if (dec_mem_op == 2'b01 || dec_mem_op == 2'b10) begin
            cap_wen       <= exu_wen && (dec_mem_op == 2'b01);
            lsu_req_valid <= 1'b1;
            timer         <= '0;
            state         <= M_REQ;
          end else begin
            cap_wen <= exu_wen;
            rf_wen  <= exu_wen && (exu_waddr != 5'd0);
            retire  <= 1'b1;
            state   <= WB;
          end
        end
        M_REQ: begin
          if (lsu_req_ready) begin
            lsu_req_valid <= 1'b0;
            timer         <= '0;
            state         <= M_WAIT;
          end else if (timer == TMAX) begin
            lsu_req_valid <= 1'b0;
            error         <= 1'b1;
            state         <= ERR;
          end else timer <= timer + 8'd1;
        end
        M_WAIT: begin
          if (lsu_resp_valid) begin
            if (cap_load) cap_wdata <= lsu_rdata;
            rf_wen <= cap_wen && (cap_waddr != 5'd0);
            retire <= 1'b1;
            state  <= WB;
          end else if (timer == TMAX) begin
            error <= 1'b1;
            state <= ERR;
          end else timer <= timer + 8'd1;
        end
        WB: begin
          pc            <= cap_npc;
          ifu_req_valid <= 1'b1;
          timer         <= '0;
          state         <= F_REQ;
        end
        default: state <= state;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (state != HALT && state != ERR) cycle_cnt <= cycle_cnt + 64'd1;
      if (retire) retire_cnt <= retire_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Self-checking bench: randomized IFU/LSU responders plus a per-instruction outcome model.
module tb_core_seq_ctrl;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk, rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_req_addr, ifu_resp_data, inst;
  logic [1:0]  dec_mem_op;
  logic        dec_halt, exu_valid, exu_wen;
  logic [4:0]  exu_waddr, rf_waddr;
  logic [31:0] exu_wdata, exu_next_pc, lsu_rdata, rf_wdata, pc;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic        rf_wen, retire, halted, error;
`ifdef SEQ_PERF_CNT_EN
  logic [63:0] cycle_cnt, retire_cnt;
`endif

  core_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .inst(inst),
    .dec_mem_op(dec_mem_op), .dec_halt(dec_halt), .exu_valid(exu_valid),
    .exu_wen(exu_wen), .exu_waddr(exu_waddr), .exu_wdata(exu_wdata), .exu_next_pc(exu_next_pc),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc(pc), .retire(retire), .halted(halted), .error(error)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt)
`endif
  );

  int n_chk = 0, n_fail = 0;
  int ifu_lo = 0, ifu_hi = 0, ifu_lat_lo = 1, ifu_lat_hi = 1;
  int lsu_lo = 0, lsu_hi = 0, lsu_lat_lo = 1, lsu_lat_hi = 1;
  bit ifu_en = 1;
  logic [31:0] cur_word = 0;
  logic [31:0] exp_pc = RPC;
  int n_retired = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  // IFU responder: random ready stall, response delay counted in wait cycles.
  bit i_pv = 0, i_pr = 0, i_on = 0, i_pend = 0;
  int i_left = 0, i_cnt = 0;
  initial begin
    ifu_req_ready = 0; ifu_resp_valid = 0; ifu_resp_data = 0;
    forever begin
      @(negedge clk);
      ifu_resp_valid = 0;
      if (i_pv && i_pr) begin i_pend = 1; i_on = 0; i_cnt = $urandom_range(ifu_lat_hi, ifu_lat_lo); end
      if (i_pend && ifu_en) begin
        if (i_cnt == 0) begin ifu_resp_valid = 1; ifu_resp_data = cur_word; i_pend = 0; end
        else i_cnt--;
      end
      if (ifu_req_valid) begin
        if (!i_on) begin i_on = 1; i_left = $urandom_range(ifu_hi, ifu_lo); end
        ifu_req_ready = (i_left == 0);
        if (i_left > 0) i_left--;
      end else ifu_req_ready = 0;
      i_pv = ifu_req_valid; i_pr = ifu_req_ready;
    end
  end

  bit l_pv = 0, l_pr = 0, l_on = 0, l_pend = 0;
  int l_left = 0, l_cnt = 0;
  initial begin
    lsu_req_ready = 0; lsu_resp_valid = 0;
    forever begin
      @(negedge clk);
      lsu_resp_valid = 0;
      if (l_pv && l_pr) begin l_pend = 1; l_on = 0; l_cnt = $urandom_range(lsu_lat_hi, lsu_lat_lo); end
      if (l_pend) begin
        if (l_cnt == 0) begin lsu_resp_valid = 1; l_pend = 0; end
        else l_cnt--;
      end
      if (lsu_req_valid) begin
        if (!l_on) begin l_on = 1; l_left = $urandom_range(lsu_hi, lsu_lo); end
        lsu_req_ready = (l_left == 0);
        if (l_left > 0) l_left--;
      end else lsu_req_ready = 0;
      l_pv = lsu_req_valid; l_pr = lsu_req_ready;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    #1;
    n_chk++;
    if ({pc, inst, ifu_req_valid, lsu_req_valid, exu_valid, rf_wen, retire, halted, error} !==
        {RPC, 32'h0, 7'b0}) begin
      n_fail++;
      $display("FAIL reset_state: pc=%h inst=%h flags=%b, required pc=%h inst=0 flags=0000000",
               pc, inst, {ifu_req_valid, lsu_req_valid, exu_valid, rf_wen, retire, halted, error}, RPC);
    end
    repeat (2) @(negedge clk);
    rst = 0;
    exp_pc = RPC;
    n_retired = 0;
  endtask

  // One instruction: expected outcome follows from the op/write rules, not from state.
  task automatic run_inst(input logic [1:0] op, input bit wen, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [31:0] npc,
                          input logic [31:0] rd, input logic [31:0] word, output int lsu_cyc);
    bit ew, done, seen_req;
    logic [31:0] ev, got_d;
    logic [4:0] got_a;
    int nw;
    dec_mem_op = op; dec_halt = 0; exu_wen = wen; exu_waddr = wa; exu_wdata = wd;
    exu_next_pc = npc; lsu_rdata = rd; cur_word = word;
    ew = (op != 2'b10) && wen && (wa != 5'd0);
    ev = (op == 2'b01) ? rd : wd;
    nw = 0; done = 0; seen_req = 0; lsu_cyc = 0; got_a = 0; got_d = 0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (ifu_req_valid && !seen_req) begin
        seen_req = 1; n_chk++;
        if (ifu_req_addr !== exp_pc) begin
          n_fail++; $display("FAIL fetch_addr: got %h required %h", ifu_req_addr, exp_pc);
        end
      end
      if (lsu_req_valid) lsu_cyc++;
      if (exu_valid) begin
        n_chk++;
        if (inst !== word) begin n_fail++; $display("FAIL inst_latch: got %h required %h", inst, word); end
      end
      if (rf_wen) begin
        nw++; got_a = rf_waddr; got_d = rf_wdata;
        n_chk++;
        if (retire !== 1'b1) begin n_fail++; $display("FAIL wen_outside_wb: retire=%b required 1", retire); end
      end
      if (retire) begin done = 1; break; end
    end
    n_chk++;
    if (!done) begin n_fail++; $display("FAIL retire_timeout: got no retire required one within 800 cycles"); end
    n_chk++;
    if (nw != (ew ? 1 : 0)) begin n_fail++; $display("FAIL rf_wen_count: got %0d required %0d", nw, ew ? 1 : 0); end
    if (ew && nw == 1) begin
      n_chk++;
      if ({got_a, got_d} !== {wa, ev}) begin
        n_fail++; $display("FAIL rf_write: got x%0d=%h required x%0d=%h", got_a, got_d, wa, ev);
      end
    end
    @(negedge clk);
    n_chk++;
    if ({ifu_req_valid, ifu_req_addr, pc} !== {1'b1, npc, npc}) begin
      n_fail++; $display("FAIL next_fetch: valid=%b addr=%h pc=%h required 1 %h %h", ifu_req_valid, ifu_req_addr, pc, npc, npc);
    end
    exp_pc = npc;
    if (done) n_retired++;
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_alu_latency();
    int rcyc, wcyc;
    ifu_lo = 0; ifu_hi = 0; ifu_lat_lo = 1; ifu_lat_hi = 1;
    dec_mem_op = 0; dec_halt = 0; exu_wen = 1; exu_waddr = 1; exu_wdata = 5;
    exu_next_pc = 32'h8000_0004; cur_word = 32'h0050_0093;
    do_reset();
    rcyc = 0; wcyc = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        n_chk++;
        if ({ifu_req_valid, ifu_req_addr} !== {1'b1, RPC}) begin
          n_fail++; $display("FAIL first_fetch: valid=%b addr=%h required 1 %h", ifu_req_valid, ifu_req_addr, RPC);
        end
      end
      if (rf_wen) begin
        wcyc++; n_chk++;
        if ({rf_waddr, rf_wdata} !== {5'd1, 32'd5}) begin
          n_fail++; $display("FAIL addi_write: got x%0d=%h required x1=00000005", rf_waddr, rf_wdata);
        end
      end
      if (retire && rcyc == 0) rcyc = c;
      if (rcyc != 0 && c == rcyc + 1) break;
    end
    n_chk++;
    if (rcyc != 5) begin n_fail++; $display("FAIL retire_latency: got cycle %0d required 5", rcyc); end
    n_chk++;
    if (wcyc != 1) begin n_fail++; $display("FAIL addi_wen_count: got %0d required 1", wcyc); end
    n_chk++;
    if (pc !== 32'h8000_0004) begin n_fail++; $display("FAIL addi_pc: got %h required 80000004", pc); end
    exp_pc = 32'h8000_0004;
  endtask

  task automatic test_x0();
    int lc;
    run_inst(2'b00, 1, 5'd0, 32'hFFFF_FFFF, exp_pc + 4, 0, 32'h0000_0013, lc);
  endtask

  task automatic test_load_store();
    int lc;
    lsu_lo = 3; lsu_hi = 3; lsu_lat_lo = 1; lsu_lat_hi = 1;
    run_inst(2'b01, 1, 5'd3, 32'hDEAD_0000, exp_pc + 4, 32'h1234_5678, 32'h0000_2183, lc);
    n_chk++;
    if (lc != 4) begin n_fail++; $display("FAIL lsu_req_hold: got %0d cycles required 4", lc); end
    run_inst(2'b10, 1, 5'd7, 32'hCAFE_F00D, exp_pc + 4, 32'h5555_AAAA, 32'h0070_2023, lc);
    lsu_lo = 0; lsu_hi = 0;
  endtask

  task automatic test_timeout();
    int k, bad;
    bit seen;
    ifu_en = 0; ifu_lo = 0; ifu_hi = 0;
    do_reset();
    seen = 0; k = -1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (ifu_req_valid) seen = 1;
      else if (seen) begin k = 0; break; end
    end
    n_chk++;
    if (k != 0) begin n_fail++; $display("FAIL timeout_handshake: got none required fetch handshake"); end
    for (int c = 1; c <= 255; c++) begin
      @(negedge clk);
      if (c == 254) begin
        n_chk++;
        if (error !== 1'b0) begin n_fail++; $display("FAIL timeout_early: error=%b at 254 required 0", error); end
      end
    end
    n_chk++;
    if (error !== 1'b1) begin n_fail++; $display("FAIL timeout_error: error=%b at 255 required 1", error); end
    bad = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ifu_req_valid || lsu_req_valid || retire || rf_wen || exu_valid || !error) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL err_terminal: got %0d active cycles required 0", bad); end
    ifu_en = 1;
  endtask

  task automatic test_halt();
    int bad;
    bit got;
    ifu_lat_lo = 0; ifu_lat_hi = 2;
    dec_mem_op = 0; dec_halt = 1; exu_wen = 1; exu_waddr = 9; exu_wdata = 32'h1;
    exu_next_pc = RPC + 4; cur_word = 32'h0010_0073;
    do_reset();
    got = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (exu_valid) begin got = 1; break; end
    end
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL halt_exec: got no exu_valid required one"); end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ifu_req_valid || rf_wen || retire || !halted) bad++;
    end
    n_chk++;
    if (bad != 0 || halted !== 1'b1) begin
      n_fail++; $display("FAIL halt_terminal: bad=%0d halted=%b required 0 and 1", bad, halted);
    end
    dec_halt = 0;
  endtask

  task automatic test_reset_mid();
    int bad, lc;
    bit seen, inwait;
    lsu_lo = 0; lsu_hi = 0; lsu_lat_lo = 6; lsu_lat_hi = 6; ifu_lat_lo = 1; ifu_lat_hi = 1;
    do_reset();
    dec_mem_op = 2'b01; dec_halt = 0; exu_wen = 1; exu_waddr = 4; exu_wdata = 0;
    exu_next_pc = RPC + 4; lsu_rdata = 32'hBAD0_BAD0; cur_word = 32'h0000_2203;
    seen = 0; inwait = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (lsu_req_valid) seen = 1;
      else if (seen) begin inwait = 1; break; end
    end
    n_chk++;
    if (!inwait) begin n_fail++; $display("FAIL mwait_reach: got no lsu handshake required one"); end
    @(negedge clk);
    #2 rst = 1; ifu_en = 0;
    #1;
    n_chk++;
    if ({pc, lsu_req_valid, rf_wen, retire} !== {RPC, 3'b0}) begin
      n_fail++; $display("FAIL async_reset: pc=%h lsu=%b wen=%b ret=%b required %h 0 0 0", pc, lsu_req_valid, rf_wen, retire, RPC);
    end
    @(negedge clk);
    rst = 0; exp_pc = RPC; n_retired = 0;
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rf_wen || retire || lsu_req_valid || pc !== RPC || (ifu_req_valid && ifu_req_addr !== RPC)) bad++;
    end
    n_chk++;
    if (bad != 0) begin n_fail++; $display("FAIL late_resp_ignored: got %0d bad cycles required 0", bad); end
    ifu_en = 1; lsu_lat_lo = 1; lsu_lat_hi = 1;
    run_inst(2'b00, 1, 5'd2, 32'h0000_00AA, RPC + 4, 0, 32'h0AA0_0113, lc);
  endtask

  task automatic test_random();
    int lc;
    logic [1:0] op;
    logic [4:0] wa;
    logic [31:0] npc;
    ifu_lo = 0; ifu_hi = 2; ifu_lat_lo = 0; ifu_lat_hi = 3;
    lsu_lo = 0; lsu_hi = 2; lsu_lat_lo = 0; lsu_lat_hi = 3;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(3, 0));
      wa = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom);
      npc = ($urandom_range(3, 0) == 0) ? ($urandom & 32'hFFFF_FFFC) : exp_pc + 4;
      run_inst(op, 1'($urandom), wa, $urandom, npc, $urandom, $urandom, lc);
    end
`ifdef SEQ_PERF_CNT_EN
    n_chk++;
    if (retire_cnt !== 64'(n_retired)) begin
      n_fail++; $display("FAIL retire_cnt: got %0d required %0d", retire_cnt, n_retired);
    end
    n_chk++;
    if (cycle_cnt < 64'(5 * n_retired)) begin
      n_fail++; $display("FAIL cycle_cnt: got %0d required at least %0d", cycle_cnt, 5 * n_retired);
    end
`endif
  endtask

  initial begin
    rst = 1; dec_mem_op = 0; dec_halt = 0; exu_wen = 0; exu_waddr = 0; exu_wdata = 0;
    exu_next_pc = 0; lsu_rdata = 0;
    test_reset();
    test_alu_latency();
    test_x0();
    test_load_store();
    test_timeout();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
Multi-cycle sequencer for the core datapath: steps each instruction through fetch, execute, optional memory access and write-back, and owns the PC register. Drives the IFU/LSU request handshakes and qualifies the EXU's write intent into a single-cycle register-file write strobe. Sits between the IFU, IDU, EXU, LSU and the register file.

Parameters:
ADDR_WIDTH, 32, PC / memory address width
DATA_WIDTH, 32, instruction / register data width
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles waiting for any response before error (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ifu_req_valid  out  1  fetch request valid
ifu_req_ready  in  1  IFU accepts request
ifu_req_addr  out  ADDR_WIDTH  fetch address (= pc)
ifu_resp_valid  in  1  instruction returned
ifu_resp_data  in  DATA_WIDTH  instruction word
inst  out  DATA_WIDTH  latched instruction to IDU
dec_mem_op  in  2  from IDU: 00 none, 01 load, 10 store, 11 treated as none
dec_halt  in  1  from IDU: ebreak decoded
exu_valid  out  1  one-cycle pulse: EXU operands/instruction valid
exu_wen  in  1  EXU write intent
exu_waddr  in  5  EXU destination register
exu_wdata  in  DATA_WIDTH  EXU result
exu_next_pc  in  ADDR_WIDTH  EXU-computed next PC
lsu_req_valid  out  1  memory request valid
lsu_req_ready  in  1  LSU accepts request
lsu_resp_valid  in  1  LSU done (load data / store ack)
lsu_rdata  in  DATA_WIDTH  load data
rf_wen  out  1  register-file write strobe
rf_waddr  out  5  register-file write address
rf_wdata  out  DATA_WIDTH  register-file write data
pc  out  ADDR_WIDTH  current PC
retire  out  1  one-cycle pulse per completed instruction
halted  out  1  sticky: ebreak reached
error  out  1  sticky: response timeout

Behaviour:
- Reset (async, immediate): state=IDLE, pc=RESET_PC, inst=0, all valid/strobe outputs 0, halted=0, error=0, timer=0. Reset mid-transaction abandons it; a late response after reset is ignored.
- States: IDLE, F_REQ, F_WAIT, EXEC, M_REQ, M_WAIT, WB, HALT, ERR.
- IDLE: one cycle after reset deasserts, then F_REQ.
- F_REQ: ifu_req_valid=1, ifu_req_addr=pc. Held stable until ifu_req_ready; on handshake go to F_WAIT.
- F_WAIT: on ifu_resp_valid latch inst<=ifu_resp_data, go to EXEC. A response in the same cycle as the request handshake is not accepted; the IFU responds no earlier than the following cycle.
- EXEC: exu_valid=1 for exactly this cycle. Capture exu_wen/waddr/wdata and exu_next_pc. If dec_halt, go to HALT (no write, no retire). Else if dec_mem_op==01/10, go to M_REQ. Else go to WB.
- M_REQ/M_WAIT: same handshake rules as fetch. Load: the captured wdata is replaced by lsu_rdata on lsu_resp_valid. Store: the captured write is suppressed.
- WB: rf_wen=1 for one cycle iff the captured wen=1 and waddr!=0 (x0 writes dropped); rf_waddr/rf_wdata come from the captured values and are held stable. Same cycle: pc<=captured next_pc, retire=1. Go to F_REQ.
- Timeout: 8-bit timer clears on entry to each of F_REQ, F_WAIT, M_REQ, M_WAIT and increments every cycle spent there. If it reaches TIMEOUT with no handshake/response: error=1, go to ERR.
- HALT, ERR: terminal until reset. All valid/strobe outputs are 0.
- Minimum latency: 5 cycles per ALU instruction (F_REQ, F_WAIT, EXEC, WB, plus a one-cycle response), with ready=1 and a 1-cycle response.
- rf_wen, exu_valid and retire are never asserted outside their stated states.

Optional Feature:
SEQ_PERF_CNT_EN: when defined, adds output ports cycle_cnt (64) and retire_cnt (64). Both reset to 0. cycle_cnt increments every cycle not in HALT/ERR. retire_cnt increments on retire. Both wrap modulo 2^64. When undefined, the ports and counters are absent and there is no other behaviour difference.

Test Plan:
- Reset, ready=1, 1-cycle responses, inst ADDI x1 (exu_wen=1, waddr=1, wdata=5, next_pc=8000_0004) -> ifu_req_addr=8000_0000; rf_wen pulses once with x1=5; pc=8000_0004; retire pulses on the 5th cycle after IDLE.
- EXU write to x0 (wen=1, waddr=0, wdata=FFFF_FFFF) -> rf_wen stays 0; retire=1; pc advances.
- Load (dec_mem_op=01, waddr=3), lsu_req_ready low for 3 cycles, lsu_rdata=1234_5678 -> lsu_req_valid held 4 cycles; rf_wen with x3=1234_5678. Store (10) -> no rf_wen.
- ifu_resp_valid never asserted -> error=1 after 255 cycles in F_WAIT; state ERR; no further requests.
- dec_halt=1 in EXEC -> halted=1; no rf_wen or retire; ifu_req_valid stays 0 for 20 cycles.
- Assert rst during M_WAIT, then deliver lsu_resp_valid -> pc=8000_0000; response ignored; fetch restarts from RESET_PC.
